// File: rtl/nest_checker.sv
// Streaming case-insensitive begin/end (and optional fork/join) nesting checker.
// A bounded type stack records which opener each nesting level came from.
module nest_checker #(
  parameter int MAX_DEPTH   = 16,
  parameter int DEPTH_W     = 5,
  parameter int ENABLE_FORK = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [7:0]         in,
  output logic               result,
  output logic [DEPTH_W-1:0] depth,
  output logic               error,
  output logic               overflow
);

  typedef enum logic [1:0] {KW_BEGIN, KW_END, KW_FORK, KW_JOIN} kw_e;

  localparam int                 IDX_W = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
  localparam logic [DEPTH_W-1:0] MAX_D = DEPTH_W'(MAX_DEPTH);

  function automatic logic [3:0] kw_len(input kw_e k);
    case (k)
      KW_BEGIN: kw_len = 4'd5;
      KW_END:   kw_len = 4'd3;
      default:  kw_len = 4'd4;
    endcase
  endfunction

  function automatic logic [7:0] kw_char(input kw_e k, input logic [3:0] p);
    logic [39:0] s;
    case (k)
      KW_BEGIN: s = "begin";
      KW_END:   s = {"end", 16'h0000};
      KW_FORK:  s = {"fork", 8'h00};
      default:  s = {"join", 8'h00};
    endcase
    case (p)
      4'd0:    kw_char = s[39:32];
      4'd1:    kw_char = s[31:24];
      4'd2:    kw_char = s[23:16];
      4'd3:    kw_char = s[15:8];
      4'd4:    kw_char = s[7:0];
      default: kw_char = 8'h00;
    endcase
  endfunction

  function automatic logic keep(input kw_e k, input logic [3:0] l, input logic [7:0] c);
    keep = (l < kw_len(k)) && (c == kw_char(k, l));
  endfunction

  logic [MAX_DEPTH-1:0] stack;
  logic [3:0]           len, len_n;
  logic [3:0]           cand, cand_n;
  logic [DEPTH_W-1:0]   depth_n, dm1;
  logic                 error_n, overflow_n;
  logic [7:0]           lc;
  logic                 is_letter, accept, delim;
  logic                 open_b, open_f, close_e, close_j;
  logic                 push, push_type, close_type, top;

  always_comb begin
    lc        = (in >= 8'h41 && in <= 8'h5A) ? (in | 8'h20) : in;
    is_letter = (lc >= 8'h61) && (lc <= 8'h7A);
    accept    = in_valid && !error;
    delim     = accept && !is_letter;
    open_b    = delim && cand[KW_BEGIN] && (len == kw_len(KW_BEGIN));
    close_e   = delim && cand[KW_END]   && (len == kw_len(KW_END));
    open_f    = delim && (ENABLE_FORK != 0) && cand[KW_FORK] && (len == kw_len(KW_FORK));
    close_j   = delim && (ENABLE_FORK != 0) && cand[KW_JOIN] && (len == kw_len(KW_JOIN));
    push_type  = open_f;
    close_type = close_j;
    dm1        = depth - DEPTH_W'(1);
    top        = stack[dm1[IDX_W-1:0]];
  end

  always_comb begin
    len_n      = len;
    cand_n     = cand;
    depth_n    = depth;
    error_n    = error;
    overflow_n = overflow;
    push       = 1'b0;
    if (accept) begin
      if (is_letter) begin
        len_n  = (len == 4'hF) ? len : len + 4'd1;
        cand_n = cand & {keep(KW_JOIN, len, lc), keep(KW_FORK, len, lc),
                         keep(KW_END, len, lc), keep(KW_BEGIN, len, lc)};
      end else begin
        len_n  = '0;
        cand_n = '1;
      end
    end
    if (open_b || open_f) begin
      if (depth < MAX_D) begin
        push    = 1'b1;
        depth_n = depth + DEPTH_W'(1);
      end else begin
        overflow_n = 1'b1;
        error_n    = 1'b1;
      end
    end else if (close_e || close_j) begin
      if (depth == '0 || top != close_type) error_n = 1'b1;
      else                                   depth_n = dm1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len      <= '0;
      cand     <= '1;
      depth    <= '0;
      error    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      len      <= len_n;
      cand     <= cand_n;
      depth    <= depth_n;
      error    <= error_n;
      overflow <= overflow_n;
    end
  end

  // Stack contents need no reset: only entries below depth are ever read.
  always_ff @(posedge clk) begin
    if (push) stack[depth[IDX_W-1:0]] <= push_type;
  end

  assign result = (depth == '0) && !error;

endmodule

// File: tb/tb_nest_checker.sv
// Scoreboard bench for nest_checker: three parameterisations share the character bus;
// a string-level reference model predicts outputs for the instance being driven.
module tb_nest_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vld0 = 1'b0, vld1 = 1'b0, vld2 = 1'b0;
  logic [7:0] in_ch = 8'h00;
  logic       r0, r1, r2, e0, e1, e2, o0, o1, o2;
  logic [4:0] d0, d2;
  logic [1:0] d1;

  nest_checker #(.MAX_DEPTH(16), .DEPTH_W(5), .ENABLE_FORK(1)) u_dut0 (
    .clk(clk), .reset(rst), .in_valid(vld0), .in(in_ch),
    .result(r0), .depth(d0), .error(e0), .overflow(o0));
  nest_checker #(.MAX_DEPTH(2), .DEPTH_W(2), .ENABLE_FORK(1)) u_dut1 (
    .clk(clk), .reset(rst), .in_valid(vld1), .in(in_ch),
    .result(r1), .depth(d1), .error(e1), .overflow(o1));
  nest_checker #(.MAX_DEPTH(16), .DEPTH_W(5), .ENABLE_FORK(0)) u_dut2 (
    .clk(clk), .reset(rst), .in_valid(vld2), .in(in_ch),
    .result(r2), .depth(d2), .error(e2), .overflow(o2));

  always #5 clk = ~clk;

  typedef struct {
    int sel;
    int depth;
    int err;
    int ovf;
    int res;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  int          m_sel = 0, m_md = 16, m_fork = 1, m_err = 0, m_ovf = 0, wl = 0;
  int          stk[$];
  logic [39:0] w = '0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int o_depth(input int s);
    case (s)
      0:       return int'(d0);
      1:       return int'(d1);
      default: return int'(d2);
    endcase
  endfunction
  function automatic int o_err(input int s);
    return (s == 0) ? int'(e0) : (s == 1) ? int'(e1) : int'(e2);
  endfunction
  function automatic int o_ovf(input int s);
    return (s == 0) ? int'(o0) : (s == 1) ? int'(o1) : int'(o2);
  endfunction
  function automatic int o_res(input int s);
    return (s == 0) ? int'(r0) : (s == 1) ? int'(r1) : int'(r2);
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check($sformatf("dut%0d_depth", e.sel), o_depth(e.sel), e.depth);
      check($sformatf("dut%0d_error", e.sel), o_err(e.sel), e.err);
      check($sformatf("dut%0d_overflow", e.sel), o_ovf(e.sel), e.ovf);
      check($sformatf("dut%0d_result", e.sel), o_res(e.sel), e.res);
    end
  end

  function automatic void m_open(input int t);
    if (stk.size() < m_md) stk.push_back(t);
    else begin
      m_ovf = 1;
      m_err = 1;
    end
  endfunction

  function automatic void m_close(input int t);
    if (stk.size() == 0)  m_err = 1;
    else if (stk[$] != t) m_err = 1;
    else                  void'(stk.pop_back());
  endfunction

  function automatic void model_char(input logic [7:0] c_in);
    logic [7:0] c;
    if (m_err != 0) return;
    c = (c_in >= "A" && c_in <= "Z") ? c_in + 8'd32 : c_in;
    if (c >= "a" && c <= "z") begin
      w  = {w[31:0], c};
      wl = wl + 1;
    end else begin
      if (wl == 5 && w == "begin")                             m_open(0);
      else if (wl == 3 && w[23:0] == "end")                    m_close(0);
      else if (m_fork != 0 && wl == 4 && w[31:0] == "fork")    m_open(1);
      else if (m_fork != 0 && wl == 4 && w[31:0] == "join")    m_close(1);
      wl = 0;
      w  = '0;
    end
  endfunction

  task automatic tick(input int v, input logic [7:0] c);
    exp_t e;
    @(negedge clk);
    #1;
    vld0  = (v != 0) && (m_sel == 0);
    vld1  = (v != 0) && (m_sel == 1);
    vld2  = (v != 0) && (m_sel == 2);
    in_ch = c;
    if (v != 0) model_char(c);
    e.sel   = m_sel;
    e.depth = stk.size();
    e.err   = m_err;
    e.ovf   = m_ovf;
    e.res   = (stk.size() == 0 && m_err == 0) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  task automatic send(input string s, input int toggle);
    for (int i = 0; i < s.len(); i++) begin
      if (toggle != 0) tick(0, "e");
      tick(1, s[i]);
    end
  endtask

  // Reset outputs are checked before any clock edge to prove the reset is asynchronous.
  task automatic do_reset(input int sel, input int md, input int fork_en);
    @(negedge clk);
    #1;
    vld0 = 1'b0;
    vld1 = 1'b0;
    vld2 = 1'b0;
    rst  = 1'b1;
    #1;
    check("rst_depth", o_depth(m_sel), 0);
    check("rst_error", o_err(m_sel), 0);
    check("rst_result", o_res(m_sel), 1);
    m_sel  = sel;
    m_md   = md;
    m_fork = fork_en;
    m_err  = 0;
    m_ovf  = 0;
    wl     = 0;
    w      = '0;
    stk.delete();
    @(negedge clk);
    #1;
    rst = 1'b0;
    tick(0, 8'h00);
  endtask

  string toks[8] = '{"begin", "end", "fork", "join", "Begin", "xend", "ends", "JOINx"};
  string seps[5] = '{" ", ",", ";", "0", "\n"};

  initial begin
    do_reset(0, 16, 1);
    send("BEGIN end ", 0);

    do_reset(0, 16, 1);
    send("begin fork end ", 0);
    send("join end ", 0);

    do_reset(0, 16, 1);
    send("end ", 0);
    do_reset(0, 16, 1);
    tick(0, 8'h00);

    do_reset(1, 2, 1);
    send("begin begin begin ", 0);

    do_reset(0, 16, 1);
    send("beginx Begin,enD;endx ", 1);

    do_reset(2, 16, 0);
    send("fork begin join end ", 0);

    do_reset(0, 16, 1);
    send("begin beg", 0);
    do_reset(0, 16, 1);
    send("in begin beginbeginbeginbegin begin0end fork join;", 0);

    do_reset(0, 16, 1);
    for (int n = 0; n < 150; n++) begin
      string tk, sp;
      tk = toks[$urandom_range(0, 7)];
      sp = seps[$urandom_range(0, 4)];
      for (int i = 0; i < tk.len(); i++) begin
        if ($urandom_range(0, 3) == 0) tick(0, "n");
        tick(1, tk[i]);
      end
      tick(1, sp[0]);
      if (m_err != 0) do_reset(0, 16, 1);
    end

    repeat (4) @(negedge clk);
    #2;
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
